// File: rtl/gpio_in.sv
// gpio_in: memory-mapped 8-bit GPIO input with 2-flop synchronizer, sticky rising-edge flags and maskable irq.
// Define GPIO_IN_DEBOUNCE_EN to insert a per-bit debounce filter between the synchronizer and PIN.
module gpio_in #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0010,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pins,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        irq
);
    localparam int unsigned NPINS = 8;
    localparam int unsigned DW    = 32;

    localparam logic [1:0] REG_PIN  = 2'd0;
    localparam logic [1:0] REG_EDGE = 2'd1;
    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_RSVD = 2'd3;

    logic [NPINS-1:0] s1;
    logic [NPINS-1:0] s2;
    logic [NPINS-1:0] level;
    logic [NPINS-1:0] level_d;
    logic [NPINS-1:0] edge_flags;
    logic [NPINS-1:0] mask;
    logic [NPINS-1:0] rise;
    logic [1:0]       arm_cnt;
    logic             armed;
    logic             hit;
    logic             rd_hit;
    logic             wr_hit;
    logic [DW-1:0]    rd_mux;
    logic             unused_ok;

    assign unused_ok = &{1'b0, wdata[31:8], addr[1:0], DEBOUNCE_CYCLES[0]};

    // Two-flop synchronizer for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pins;
            s2 <= s1;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int unsigned CNTW = 16;
    localparam logic [CNTW-1:0] DB_LAST = CNTW'(DEBOUNCE_CYCLES - 1);

    logic [CNTW-1:0] db_cnt [NPINS];

    // A bit's level only follows s2 after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            for (int unsigned i = 0; i < NPINS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NPINS; i++) begin
                if (s2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNTW'(1);
                end
            end
        end
    end
`else
    assign level = s2;
`endif

    assign armed  = (arm_cnt == 2'd3);
    assign rise   = level & ~level_d & {NPINS{armed}};
    assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
    assign rd_hit = rd_en & hit;
    assign wr_hit = wr_en & hit;

    always_comb begin
        rd_mux = '0;
        case (addr[3:2])
            REG_PIN:  rd_mux = DW'(level);
            REG_EDGE: rd_mux = DW'(edge_flags);
            REG_MASK: rd_mux = DW'(mask);
            REG_RSVD: rd_mux = '0;
            default:  rd_mux = '0;
        endcase
    end

    // Edge flags: a rise in the read-clear cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_d    <= '0;
            arm_cnt    <= '0;
            edge_flags <= '0;
            mask       <= '0;
            rdata      <= '0;
            rvalid     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            level_d <= level;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            if (rd_hit && (addr[3:2] == REG_EDGE)) begin
                edge_flags <= rise;
            end else begin
                edge_flags <= edge_flags | rise;
            end
            if (wr_hit && (addr[3:2] == REG_MASK)) begin
                mask <= wdata[NPINS-1:0];
            end
            rvalid <= rd_hit;
            if (rd_hit) begin
                rdata <= rd_mux;
            end
            irq <= |(edge_flags & mask);
        end
    end
endmodule

// File: tb/tb_gpio_in.sv
// Directed self-checking bench for gpio_in; inputs change 1 time unit after posedge, outputs sampled there too.
module tb_gpio_in;
    localparam logic [31:0] BASE     = 32'hFFFF_0010;
    localparam logic [31:0] OFF_PIN  = 32'h0;
    localparam logic [31:0] OFF_EDGE = 32'h4;
    localparam logic [31:0] OFF_MASK = 32'h8;
    localparam logic [31:0] OFF_RSVD = 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pins;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    gpio_in #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .pins   (pins),
        .addr   (addr),
        .rd_en  (rd_en),
        .wr_en  (wr_en),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_read(input logic [31:0] off, input logic [31:0] exp, input string tag);
        addr  = BASE + off;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, " rvalid"}, 32'(rvalid), 32'd1);
        check(tag, rdata, exp);
    endtask

    task automatic cpu_write(input logic [31:0] off, input logic [31:0] data);
        addr  = BASE + off;
        wdata = data;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
`ifdef GPIO_IN_DEBOUNCE_EN
        pins = 8'h00;
        ticks(3);
        rst = 1'b0;
        ticks(10);
        cpu_write(OFF_MASK, 32'h01);
        // A 10-cycle glitch never reaches PIN or EDGE.
        pins = 8'h01;
        ticks(10);
        pins = 8'h00;
        ticks(30);
        cpu_read(OFF_PIN, 32'h0, "glitch pin");
        cpu_read(OFF_EDGE, 32'h0, "glitch edge");
        check("glitch irq", 32'(irq), 32'd0);
        // A held level is accepted at +18, edge flag the cycle after.
        pins = 8'h01;
        ticks(17);
        addr  = BASE + OFF_PIN;
        rd_en = 1'b1;
        tick();
        check("db pin at +18 (pre-update)", rdata, 32'h0);
        tick();
        check("db pin after +18", rdata, 32'h1);
        addr = BASE + OFF_EDGE;
        tick();
        rd_en = 1'b0;
        check("db edge", rdata, 32'h1);
`else
        // Reset and arming with pins already high.
        pins = 8'hFF;
        ticks(3);
        check("reset rdata", rdata, 32'h0);
        check("reset rvalid", 32'(rvalid), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        rst = 1'b0;
        ticks(10);
        cpu_read(OFF_EDGE, 32'h0, "arm edge");
        check("arm irq", 32'(irq), 32'd0);
        cpu_read(OFF_PIN, 32'h0000_00FF, "arm pin");
        tick();
        check("rvalid pulse width", 32'(rvalid), 32'd0);

        // Unmasked edge capture and read-to-clear.
        cpu_write(OFF_MASK, 32'h05);
        pins = 8'h00;
        ticks(5);
        check("falling edge no irq", 32'(irq), 32'd0);
        pins = 8'h01;
        ticks(3);
        check("irq at +3", 32'(irq), 32'd0);
        tick();
        check("irq at +4", 32'(irq), 32'd1);
        cpu_read(OFF_EDGE, 32'h01, "edge capture");
        check("irq in clear cycle", 32'(irq), 32'd1);
        tick();
        check("irq after clear", 32'(irq), 32'd0);
        cpu_read(OFF_EDGE, 32'h0, "edge reread");
        cpu_read(OFF_PIN, 32'h01, "pin level");

        // Masked edge, then unmask.
        cpu_write(OFF_MASK, 32'h00);
        pins = 8'h03;
        ticks(5);
        check("masked irq", 32'(irq), 32'd0);
        cpu_write(OFF_MASK, 32'h02);
        check("irq in mask write cycle", 32'(irq), 32'd0);
        tick();
        check("irq after unmask", 32'(irq), 32'd1);
        cpu_read(OFF_EDGE, 32'h02, "masked edge");

        // Clear collision: bit3 rises in the EDGE-read cycle.
        pins = 8'h02;
        ticks(4);
        pins = 8'h03;
        ticks(5);
        pins = 8'h0B;
        ticks(2);
        addr  = BASE + OFF_EDGE;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("collision read", rdata, 32'h01);
        cpu_read(OFF_EDGE, 32'h08, "collision survivor");

        // Decode and write filtering.
        addr  = BASE + 32'h20;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("decode miss rvalid", 32'(rvalid), 32'd0);
        check("decode miss rdata hold", rdata, 32'h08);
        cpu_read(OFF_RSVD, 32'h0, "reserved read");
        cpu_write(OFF_PIN, 32'hFFFF_FFFF);
        cpu_write(OFF_EDGE, 32'hFFFF_FFFF);
        cpu_write(OFF_RSVD, 32'hFFFF_FFFF);
        cpu_read(OFF_PIN, 32'h0B, "pin after write");
        cpu_read(OFF_EDGE, 32'h0, "edge after write");
        cpu_read(OFF_MASK, 32'h02, "mask after ignored writes");
        addr  = BASE + OFF_MASK;
        wdata = 32'h0000_00A5;
        rd_en = 1'b1;
        wr_en = 1'b1;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        check("rd+wr returns old", rdata, 32'h02);
        cpu_write(32'h28, 32'h0);
        cpu_read(OFF_MASK, 32'hA5, "mask after rd+wr");

        // Reset mid-operation drops the pending read and re-arms.
        addr  = BASE + OFF_PIN;
        rd_en = 1'b1;
        rst   = 1'b1;
        tick();
        rd_en = 1'b0;
        check("mid reset rvalid", 32'(rvalid), 32'd0);
        check("mid reset rdata", rdata, 32'h0);
        ticks(2);
        rst = 1'b0;
        ticks(10);
        cpu_write(OFF_MASK, 32'hFF);
        ticks(2);
        check("rearm irq", 32'(irq), 32'd0);
        cpu_read(OFF_EDGE, 32'h0, "rearm edge");
        cpu_read(OFF_PIN, 32'h0B, "rearm pin");
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
